// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the memory stage: Y86 icodes, stat codes and the
// access FSM states.
package memory_access_unit_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'b00,
    MAU_REQ  = 2'b01,
    MAU_WAIT = 2'b10,
    MAU_DONE = 2'b11
  } mau_state_e;

endpackage

// File: rtl/dmem_addr_check.sv
// Decodes the icode into read/write intent, selects the access address and
// checks that the full 8-byte access fits inside data memory.
module dmem_addr_check
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  output logic        rd_o,
  output logic        wr_o,
  output logic [63:0] addr_o,
  output logic        legal_o
);

  // Comparing against the last legal start address avoids computing addr+8,
  // which could wrap for addresses near 2^64.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  always_comb begin
    rd_o   = 1'b0;
    wr_o   = 1'b0;
    addr_o = valE_i;
    case (icode_i)
      I_MRMOVQ: rd_o = 1'b1;
      I_POPQ, I_RET: begin
        rd_o   = 1'b1;
        addr_o = valA_i;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: wr_o = 1'b1;
      default: ;
    endcase
    legal_o = (addr_o <= LAST_ADDR);
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: one 8-byte access per instruction over a req/gnt/rvalid bus,
// stalling the pipeline until the access completes, errors or times out.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_stall_o
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_e       state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      valM_q, valM_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        acc_rd, acc_wr, acc_legal, need, timeout;
  logic [63:0] acc_addr;

  dmem_addr_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .icode_i (M_icode_i),
    .valE_i  (M_valE_i),
    .valA_i  (M_valA_i),
    .rd_o    (acc_rd),
    .wr_o    (acc_wr),
    .addr_o  (acc_addr),
    .legal_o (acc_legal)
  );

  assign need    = (acc_rd || acc_wr) && (M_stat_i == SAOK);
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MAU_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      valM_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      valM_q  <= valM_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    valM_d  = valM_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      MAU_IDLE: begin
        if (need) begin
          cnt_d  = '0;
          valM_d = '0;
          if (acc_legal) begin
            addr_d  = acc_addr;
            we_d    = acc_wr;
            wdata_d = M_valA_i;
            err_d   = 1'b0;
            state_d = MAU_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = MAU_DONE;
          end
        end
      end
      MAU_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = MAU_DONE;
        end else if (dmem_gnt_i) begin
          state_d = MAU_WAIT;
        end
      end
      MAU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the final budgeted cycle still counts as success.
        if (dmem_rvalid_i) begin
          valM_d  = we_q ? 64'd0 : dmem_rdata_i;
          err_d   = dmem_err_i;
          state_d = MAU_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = MAU_DONE;
        end
      end
      default: state_d = MAU_IDLE;
    endcase
  end

  // Stall is gated by reset so the pipeline is released while reset is held.
  always_comb begin
    dmem_req_o   = (state_q == MAU_REQ);
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_wdata_o = wdata_q;
    m_stall_o    = rst_n_i && (((state_q == MAU_IDLE) && need) ||
                               (state_q == MAU_REQ) || (state_q == MAU_WAIT));
    m_valM_o     = (state_q == MAU_DONE) ? valM_q : 64'd0;
    m_stat_o     = ((state_q == MAU_DONE) && err_q) ? SADR : M_stat_i;
  end

endmodule
